// File: rtl/video_pat_pkg.sv
// Shared types and constants for the video test-pattern generator.
package video_pat_pkg;

   typedef enum logic [1:0] {
      MODE_FLAT  = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_SWEEP = 2'd2,
      MODE_BARS  = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   typedef struct packed {
      logic neg;
      logic dbl;
   } chroma_ent_t;

   // Phase 7 down to 0: {+1, +2, +2, +1, -1, -2, -2, -1} read from phase 0 upward
   localparam chroma_ent_t [7:0] CHROMA_TAB = {2'b10, 2'b11, 2'b11, 2'b10,
                                               2'b00, 2'b01, 2'b01, 2'b00};

   localparam int LATENCY = 3;

endpackage

// File: rtl/video_pat_chroma_lut.sv
// Subcarrier phase to signed chroma amplitude (1x or 2x C_CAMP).
module video_pat_chroma_lut
   import video_pat_pkg::*;
#(
   parameter int C_CAMP = 3,
   parameter int C_W    = 7
) (
   input  logic [2:0]            phase_i,
   output logic signed [C_W-1:0] chroma_o
);

   localparam logic signed [C_W-1:0] AMP1 = C_W'(C_CAMP);
   localparam logic signed [C_W-1:0] AMP2 = C_W'(2 * C_CAMP);

   chroma_ent_t ent_s;

   always_comb begin
      ent_s = CHROMA_TAB[phase_i];
      case ({ent_s.neg, ent_s.dbl})
         2'b00:   chroma_o = AMP1;
         2'b01:   chroma_o = AMP2;
         2'b10:   chroma_o = -AMP1;
         2'b11:   chroma_o = -AMP2;
         default: chroma_o = AMP1;
      endcase
   end

endmodule

// File: rtl/video_pat_gen.sv
// Composite test-pattern mixer: 3-stage pipeline plus frame-synchronous mode handshake.
// Optional fade-in after each mode change is enabled by defining VIDEO_PAT_FADE_EN.
module video_pat_gen
   import video_pat_pkg::*;
#(
   parameter int C_VW       = 5,
   parameter int C_PEDE     = 12,
   parameter int C_CAMP     = 3,
   parameter int C_MODE_RST = 1
) (
   input  logic            CK_i,
   input  logic            RST_i,
   input  logic            CK_EE_i,
   input  logic [9:0]      HCTRs_i,
   input  logic [8:0]      VCTRs_i,
   input  logic [7:0]      FCTRs_i,
   input  logic            XBLK_i,
   input  logic            COLOR_BAR_NOW_i,
   input  logic            XSYNC_i,
   input  logic [2:0]      CPHs_i,
   input  logic [1:0]      MODE_i,
   input  logic            MODE_REQ_i,
   output logic            MODE_ACK_o,
   output logic [1:0]      MODE_o,
   output logic [C_VW-1:0] VIDEOs_o
);

   localparam int SW = C_VW + 2;
   localparam int FW = C_VW + 4;
   localparam logic signed [SW-1:0] PEDE_S = SW'(C_PEDE);
   localparam logic [C_VW-1:0]      PEDE_V = C_VW'(C_PEDE);

   function automatic logic signed [FW-1:0] fade_f(input logic signed [FW-1:0] x,
                                                  input logic [2:0] k);
      logic signed [FW-1:0] p;
      case (k)
         3'd0:    p = '0;
         3'd1:    p = x;
         3'd2:    p = x <<< 1;
         3'd3:    p = x + (x <<< 1);
         default: p = x <<< 2;
      endcase
      return p >>> 2;
   endfunction

   function automatic logic [C_VW-1:0] clip_f(input logic signed [SW-1:0] s);
      if (s[SW-1])
         return '0;
      else if (s[SW-2])
         return '1;
      else
         return s[C_VW-1:0];
   endfunction

   state_e state_q;
   mode_e  mode_q, pend_q;
   logic   ack_q;
   logic   frame_start_s;

   assign frame_start_s = (HCTRs_i == 10'd0) && (VCTRs_i == 9'd0);

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         state_q <= ST_IDLE;
         mode_q  <= mode_e'(2'(C_MODE_RST));
         pend_q  <= MODE_FLAT;
         ack_q   <= 1'b0;
      end else if (CK_EE_i) begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (MODE_REQ_i) begin
                  pend_q  <= mode_e'(MODE_i);
                  state_q <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (frame_start_s) begin
                  mode_q  <= pend_q;
                  ack_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
               // A request coinciding with the apply is queued for the next frame
               if (MODE_REQ_i) begin
                  pend_q  <= mode_e'(MODE_i);
                  state_q <= ST_PEND;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic [2:0] s1_k_s;

`ifdef VIDEO_PAT_FADE_EN
   logic [2:0] fade_k_q, s1_k_q;
   logic       apply_s;

   assign apply_s = (state_q == ST_PEND) && frame_start_s;

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         fade_k_q <= 3'd4;
         s1_k_q   <= 3'd4;
      end else if (CK_EE_i) begin
         if (apply_s)
            fade_k_q <= 3'd0;
         else if (frame_start_s && (fade_k_q != 3'd4))
            fade_k_q <= fade_k_q + 3'd1;
         s1_k_q <= fade_k_q;
      end
   end

   assign s1_k_s = s1_k_q;
`else
   assign s1_k_s = 3'd4;
`endif

   logic [7:0] s1_h_q, s1_v_q, s1_f_q;
   logic [2:0] s1_cph_q;
   logic       s1_xblk_q, s1_burst_q, s1_xsync_q;
   mode_e      s1_mode_q;

   logic              s2_xblk_q, s2_burst_q, s2_xsync_q;
   logic signed [SW-1:0] s2_delta_q, s2_chroma_q, s2_bst_q;
   logic signed [SW-1:0] s2_delta_d, s2_chroma_d;
   logic [C_VW-1:0]   video_q, video_d;

   logic [7:0]           r_s;
   logic [2:0]           bar_s, inv_bar_s, act_ph_s, bst_ph_s;
   logic signed [SW-1:0] act_c_s, bst_c_s;
   logic signed [FW-1:0] delta_s, chroma_s;
   logic signed [SW-1:0] sum_s;

   assign bar_s     = s1_h_q[7:5];
   assign inv_bar_s = 3'd7 - bar_s;
   assign act_ph_s  = s1_cph_q + bar_s;
   assign bst_ph_s  = s1_cph_q + 3'd4;

   video_pat_chroma_lut #(.C_CAMP(C_CAMP), .C_W(SW)) u_lut_act (
      .phase_i  (act_ph_s),
      .chroma_o (act_c_s)
   );

   video_pat_chroma_lut #(.C_CAMP(C_CAMP), .C_W(SW)) u_lut_bst (
      .phase_i  (bst_ph_s),
      .chroma_o (bst_c_s)
   );

   always_comb begin
      r_s      = s1_h_q + s1_v_q + s1_f_q;
      delta_s  = '0;
      chroma_s = '0;
      case (s1_mode_q)
         MODE_FLAT: begin
            delta_s  = '0;
            chroma_s = '0;
         end
         MODE_RAMP: begin
            delta_s  = FW'({r_s >> (10 - C_VW), 1'b0});
            chroma_s = '0;
         end
         MODE_SWEEP: begin
            delta_s  = FW'({r_s >> (10 - C_VW), 1'b0});
            chroma_s = FW'(act_c_s);
         end
         MODE_BARS: begin
            delta_s = FW'(inv_bar_s) << (C_VW - 4);
            if ((bar_s == 3'd0) || (bar_s == 3'd7))
               chroma_s = '0;
            else
               chroma_s = FW'(act_c_s);
         end
         default: begin
            delta_s  = '0;
            chroma_s = '0;
         end
      endcase
      s2_delta_d  = SW'(fade_f(delta_s, s1_k_s));
      s2_chroma_d = SW'(fade_f(chroma_s, s1_k_s));
   end

   // Output select: sync beats burst beats blank beats active picture
   always_comb begin
      sum_s   = '0;
      video_d = PEDE_V;
      if (!s2_xsync_q) begin
         video_d = '0;
      end else if (s2_burst_q) begin
         sum_s   = PEDE_S + s2_bst_q;
         video_d = clip_f(sum_s);
      end else if (!s2_xblk_q) begin
         video_d = PEDE_V;
      end else begin
         sum_s   = PEDE_S + s2_delta_q + s2_chroma_q;
         video_d = clip_f(sum_s);
      end
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         s1_h_q      <= 8'd0;
         s1_v_q      <= 8'd0;
         s1_f_q      <= 8'd0;
         s1_cph_q    <= 3'd0;
         s1_xblk_q   <= 1'b0;
         s1_burst_q  <= 1'b0;
         s1_xsync_q  <= 1'b1;
         s1_mode_q   <= MODE_FLAT;
         s2_xblk_q   <= 1'b0;
         s2_burst_q  <= 1'b0;
         s2_xsync_q  <= 1'b1;
         s2_delta_q  <= '0;
         s2_chroma_q <= '0;
         s2_bst_q    <= '0;
         video_q     <= PEDE_V;
      end else if (CK_EE_i) begin
         s1_h_q      <= HCTRs_i[8:1];
         s1_v_q      <= VCTRs_i[7:0];
         s1_f_q      <= FCTRs_i;
         s1_cph_q    <= CPHs_i;
         s1_xblk_q   <= XBLK_i;
         s1_burst_q  <= COLOR_BAR_NOW_i;
         s1_xsync_q  <= XSYNC_i;
         s1_mode_q   <= mode_q;
         s2_xblk_q   <= s1_xblk_q;
         s2_burst_q  <= s1_burst_q;
         s2_xsync_q  <= s1_xsync_q;
         s2_delta_q  <= s2_delta_d;
         s2_chroma_q <= s2_chroma_d;
         s2_bst_q    <= bst_c_s;
         video_q     <= video_d;
      end
   end

   assign VIDEOs_o   = video_q;
   assign MODE_o     = mode_q;
   assign MODE_ACK_o = ack_q & CK_EE_i;

endmodule

// File: tb/tb_video_pat_gen.sv
// Directed self-checking bench for video_pat_gen at default parameters.
module tb_video_pat_gen;
   import video_pat_pkg::*;

   logic       clk = 1'b0;
   logic       rst, ee, xblk, burst, xsync, req, ack;
   logic [9:0] hctr;
   logic [8:0] vctr;
   logic [7:0] fctr;
   logic [2:0] cph;
   logic [1:0] mode_in, mode_out;
   logic [4:0] video;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   video_pat_gen dut (
      .CK_i            (clk),
      .RST_i           (rst),
      .CK_EE_i         (ee),
      .HCTRs_i         (hctr),
      .VCTRs_i         (vctr),
      .FCTRs_i         (fctr),
      .XBLK_i          (xblk),
      .COLOR_BAR_NOW_i (burst),
      .XSYNC_i         (xsync),
      .CPHs_i          (cph),
      .MODE_i          (mode_in),
      .MODE_REQ_i      (req),
      .MODE_ACK_o      (ack),
      .MODE_o          (mode_out),
      .VIDEOs_o        (video)
   );

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [9:0] h, input logic [8:0] v, input logic [7:0] f,
                        input logic bl, input logic bu, input logic sy, input logic [2:0] c);
      hctr = h; vctr = v; fctr = f; xblk = bl; burst = bu; xsync = sy; cph = c;
      step(LATENCY);
   endtask

   task automatic do_req(input logic [1:0] m);
      mode_in = m;
      req     = 1'b1;
      step(1);
      req     = 1'b0;
   endtask

   // Brings the fade level (when built in) back to full scale after an apply
   task automatic frames4();
      for (int i = 0; i < 4; i++) begin
         hctr = 10'd0; vctr = 9'd0;
         step(1);
         vctr = 9'd1;
         step(1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      hctr = 10'h1FE; vctr = 9'd0; fctr = 8'd0; xblk = 1'b1; xsync = 1'b1;
      step(4);
      n_cmp++; if (video !== 5'd12) begin n_fail++; $display("FAIL reset_video: got %0d want 12", video); end
      n_cmp++; if (mode_out !== 2'd1) begin n_fail++; $display("FAIL reset_mode: got %0d want 1", mode_out); end
      n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b want 0", ack); end
      rst = 1'b0;
      step(2);
      n_cmp++; if (video !== 5'd12) begin n_fail++; $display("FAIL reset_latency2: got %0d want 12", video); end
      step(1);
      n_cmp++; if (video !== 5'd26) begin n_fail++; $display("FAIL reset_latency3: got %0d want 26", video); end
   endtask

   task automatic test_sync_burst();
      drive(10'h1FE, 9'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0);
      n_cmp++; if (video !== 5'd0) begin n_fail++; $display("FAIL sync: got %0d want 0", video); end
      drive(10'h1FE, 9'd0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0);
      n_cmp++; if (video !== 5'd0) begin n_fail++; $display("FAIL sync_over_burst: got %0d want 0", video); end
      drive(10'h1FE, 9'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd9) begin n_fail++; $display("FAIL burst_p0: got %0d want 9", video); end
      drive(10'h1FE, 9'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'd2);
      n_cmp++; if (video !== 5'd6) begin n_fail++; $display("FAIL burst_p2: got %0d want 6", video); end
      drive(10'h1FE, 9'd0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd2);
      n_cmp++; if (video !== 5'd12) begin n_fail++; $display("FAIL blank: got %0d want 12", video); end
   endtask

   task automatic test_ramp();
      drive(10'h080, 9'd32, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd18) begin n_fail++; $display("FAIL ramp_r96: got %0d want 18", video); end
      drive(10'h002, 9'd1, 8'd160, 1'b1, 1'b0, 1'b1, 3'd5);
      n_cmp++; if (video !== 5'd22) begin n_fail++; $display("FAIL ramp_r162: got %0d want 22", video); end
   endtask

   task automatic test_handshake();
      int acks;
      hctr = 10'd5; vctr = 9'd100;
      do_req(2'd3);
      n_cmp++; if (mode_out !== 2'd1) begin n_fail++; $display("FAIL hs_pending_mode: got %0d want 1", mode_out); end
      vctr = 9'd150;
      do_req(2'd0);
      acks = 0;
      for (int i = 0; i < 5; i++) begin step(1); if (ack) acks++; end
      n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL hs_early_ack: got %0d want 0", acks); end
      hctr = 10'd0; vctr = 9'd0;
      step(1);
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack: got %0b want 1", ack); end
      n_cmp++; if (mode_out !== 2'd0) begin n_fail++; $display("FAIL hs_last_wins: got %0d want 0", mode_out); end
      vctr = 9'd1;
      step(1);
      n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL hs_ack_pulse: got %0b want 0", ack); end
      // request landing on the apply cycle
      hctr = 10'd5; vctr = 9'd7;
      do_req(2'd3);
      hctr = 10'd0; vctr = 9'd0; mode_in = 2'd2; req = 1'b1;
      step(1);
      req = 1'b0;
      n_cmp++; if (ack !== 1'b1 || mode_out !== 2'd3) begin n_fail++; $display("FAIL hs_coincide_apply: got ack=%0b mode=%0d want ack=1 mode=3", ack, mode_out); end
      vctr = 9'd1;
      acks = 0;
      for (int i = 0; i < 3; i++) begin step(1); if (ack) acks++; end
      n_cmp++; if (acks !== 0 || mode_out !== 2'd3) begin n_fail++; $display("FAIL hs_coincide_hold: got acks=%0d mode=%0d want 0/3", acks, mode_out); end
      hctr = 10'd0; vctr = 9'd0;
      step(1);
      n_cmp++; if (ack !== 1'b1 || mode_out !== 2'd2) begin n_fail++; $display("FAIL hs_second_ack: got ack=%0b mode=%0d want ack=1 mode=2", ack, mode_out); end
      vctr = 9'd1;
      step(1);
      do_req(2'd2);
      hctr = 10'd0; vctr = 9'd0;
      step(1);
      n_cmp++; if (ack !== 1'b1 || mode_out !== 2'd2) begin n_fail++; $display("FAIL hs_same_mode: got ack=%0b mode=%0d want ack=1 mode=2", ack, mode_out); end
      vctr = 9'd1;
      step(1);
   endtask

   task automatic test_enable_bars();
      hctr = 10'd5; vctr = 9'd1;
      do_req(2'd3);
      ee = 1'b0;
      hctr = 10'd0; vctr = 9'd0;
      step(2);
      n_cmp++; if (ack !== 1'b0 || mode_out !== 2'd2) begin n_fail++; $display("FAIL en_hold: got ack=%0b mode=%0d want ack=0 mode=2", ack, mode_out); end
      ee = 1'b1;
      step(1);
      n_cmp++; if (ack !== 1'b1 || mode_out !== 2'd3) begin n_fail++; $display("FAIL en_apply: got ack=%0b mode=%0d want ack=1 mode=3", ack, mode_out); end
      frames4();
      drive(10'h0C0, 9'd5, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd23) begin n_fail++; $display("FAIL bars_b3: got %0d want 23", video); end
      ee = 1'b0;
      drive(10'h1C0, 9'd5, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd23) begin n_fail++; $display("FAIL en_pipe_hold: got %0d want 23", video); end
      ee = 1'b1;
      step(LATENCY);
      n_cmp++; if (video !== 5'd12) begin n_fail++; $display("FAIL bars_b7: got %0d want 12", video); end
      drive(10'h000, 9'd5, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd26) begin n_fail++; $display("FAIL bars_b0: got %0d want 26", video); end
      drive(10'h140, 9'd5, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd10) begin n_fail++; $display("FAIL bars_b5: got %0d want 10", video); end
   endtask

   task automatic test_sweep_flat();
      hctr = 10'd5; vctr = 9'd1;
      do_req(2'd2);
      frames4();
      drive(10'h1FE, 9'd0, 8'd0, 1'b1, 1'b0, 1'b1, 3'd2);
      n_cmp++; if (video !== 5'd31) begin n_fail++; $display("FAIL sweep_clip: got %0d want 31", video); end
      drive(10'h080, 9'd32, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd24) begin n_fail++; $display("FAIL sweep_b2: got %0d want 24", video); end
      hctr = 10'd5; vctr = 9'd1;
      do_req(2'd0);
      frames4();
      drive(10'h1FE, 9'd0, 8'd0, 1'b1, 1'b0, 1'b1, 3'd2);
      n_cmp++; if (video !== 5'd12) begin n_fail++; $display("FAIL flat: got %0d want 12", video); end
   endtask

`ifdef VIDEO_PAT_FADE_EN
   task automatic test_fade();
      logic [4:0] want;
      hctr = 10'd5; vctr = 9'd1;
      do_req(2'd1);
      hctr = 10'd0; vctr = 9'd0;
      step(1);
      drive(10'h100, 9'd1, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
      n_cmp++; if (video !== 5'd12) begin n_fail++; $display("FAIL fade_k0: got %0d want 12", video); end
      for (int i = 1; i <= 5; i++) begin
         hctr = 10'd0; vctr = 9'd0;
         step(1);
         drive(10'h100, 9'd1, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0);
         want = (i >= 4) ? 5'd20 : 5'(12 + 2 * i);
         n_cmp++; if (video !== want) begin n_fail++; $display("FAIL fade_frame%0d: got %0d want %0d", i, video, want); end
      end
   endtask
`endif

   initial begin
      rst = 1'b1; ee = 1'b1; req = 1'b0; mode_in = 2'd0;
      hctr = 10'h1FE; vctr = 9'd0; fctr = 8'd0;
      xblk = 1'b1; burst = 1'b0; xsync = 1'b1; cph = 3'd0;
      test_reset();
      test_sync_burst();
      test_ramp();
      test_handshake();
      test_enable_bars();
      test_sweep_flat();
`ifdef VIDEO_PAT_FADE_EN
      test_fade();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
